interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_pkg.sv | 21 ++
 rtl/interrupt_controller_irq_edge_sync.sv | 25 ++
 rtl/interrupt_controller.sv | 100 ++++++++++
 tb/tb_interrupt_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, vector layout, priority helper.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } ic_state_e;

    localparam logic [15:0] VEC_BASE_DEFAULT = 16'h0040;
    localparam logic [15:0] VEC_STRIDE       = 16'd4;

    // Lowest set bit index wins; returns 0 for an all-zero input.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/interrupt_controller_irq_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector on the synchronized value.
module irq_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic rise
);

    logic sync1, sync2, sync2_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= irq;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign rise = sync2 & ~sync2_d;

endmodule

// File: rtl/interrupt_controller.sv
// Single-level interrupt controller: edge-latched pending bits, fixed lowest-index priority, no nesting.
//   state      | meaning
//   ST_IDLE    | arbitrating (pending & mask) each cycle
//   ST_REQUEST | winner frozen, int_req offered to the CPU
//   ST_SERVICE | handler running, waiting for int_done
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_IRQ  = 4,
    parameter logic [15:0] VEC_BASE = VEC_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_write,
    input  logic [NUM_IRQ-1:0] mask_in,
    input  logic               int_ack,
    input  logic               int_done,
    output logic               int_req,
    output logic [15:0]        int_vector,
    output logic               int_reg_i,
    output logic               int_reg_write,
    output logic [NUM_IRQ-1:0] pending
);

    ic_state_e          state;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [2:0]         winner;
    logic [2:0]         cand;
    logic [15:0]        cand_vec;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_edge_sync u_sync (
            .clk   (clk),
            .reset (reset),
            .irq   (irq[g]),
            .rise  (rise[g])
        );
    end

    always_comb begin
        cand     = lowest_set(8'(pending & mask));
        cand_vec = VEC_BASE + VEC_STRIDE * {13'd0, cand};
    end

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_clr[i] = (state == ST_REQUEST) && int_ack && (winner == 3'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            pending       <= '0;
            mask          <= '1;
            winner        <= 3'd0;
            int_req       <= 1'b0;
            int_vector    <= VEC_BASE;
            int_reg_i     <= 1'b0;
            int_reg_write <= 1'b0;
        end else begin
            int_reg_write <= 1'b0;
            int_reg_i     <= 1'b0;
            // A fresh edge in the same cycle as the acknowledge clear keeps the bit set.
            pending       <= (pending & ~ack_clr) | rise;
            if (mask_write) mask <= mask_in;

            case (state)
                ST_IDLE: begin
                    if ((pending & mask) != '0) begin
                        winner     <= cand;
                        int_vector <= cand_vec;
                        int_req    <= 1'b1;
                        state      <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (int_ack) begin
                        int_req       <= 1'b0;
                        int_reg_write <= 1'b1;
                        int_reg_i     <= 1'b1;
                        state         <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (int_done) begin
                        int_reg_write <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus random traffic, all checked against a behavioural model of the controller.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq;
    logic        mask_write;
    logic [3:0]  mask_in;
    logic        int_ack;
    logic        int_done;
    logic        int_req;
    logic [15:0] int_vector;
    logic        int_reg_i;
    logic        int_reg_write;
    logic [3:0]  pending;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [3:0]  m_pending, m_mask, h1, h2, h3;
    int          m_phase;   // 0 idle, 1 offering, 2 servicing
    int          m_winner;
    logic        m_req, m_wr, m_ri;
    logic [15:0] m_vec;

    interrupt_controller #(.NUM_IRQ(4), .VEC_BASE(16'h0040)) dut (
        .clk           (clk),
        .reset         (reset),
        .irq           (irq),
        .mask_write    (mask_write),
        .mask_in       (mask_in),
        .int_ack       (int_ack),
        .int_done      (int_done),
        .int_req       (int_req),
        .int_vector    (int_vector),
        .int_reg_i     (int_reg_i),
        .int_reg_write (int_reg_write),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [3:0] iv, input logic mw,
                              input logic [3:0] mi, input logic a, input logic d);
        logic [3:0] rise;
        logic [3:0] clr;
        logic [3:0] elig;
        if (r) begin
            m_pending = '0; m_mask = '1; h1 = '0; h2 = '0; h3 = '0;
            m_phase = 0; m_winner = 0;
            m_req = 0; m_vec = 16'h0040; m_wr = 0; m_ri = 0;
            return;
        end
        // an edge seen on the input two samples ago lands in pending now
        rise = h2 & ~h3;
        clr  = '0;
        elig = m_pending & m_mask;
        m_wr = 0;
        m_ri = 0;
        if (m_phase == 0) begin
            if (elig != 0) begin
                for (int i = 3; i >= 0; i--) if (elig[i]) m_winner = i;
                m_phase = 1;
                m_req   = 1;
                m_vec   = 16'h0040 + 16'(4 * m_winner);
            end
        end else if (m_phase == 1) begin
            if (a) begin
                clr[m_winner] = 1'b1;
                m_phase = 2; m_req = 0; m_wr = 1; m_ri = 1;
            end
        end else begin
            if (d) begin
                m_phase = 0; m_wr = 1;
            end
        end
        m_pending = (m_pending & ~clr) | rise;
        if (mw) m_mask = mi;
        h3 = h2; h2 = h1; h1 = iv;
    endtask

    task automatic tick(input logic r, input logic [3:0] iv, input logic mw,
                        input logic [3:0] mi, input logic a, input logic d);
        reset = r; irq = iv; mask_write = mw; mask_in = mi; int_ack = a; int_done = d;
        @(posedge clk);
        model_edge(r, iv, mw, mi, a, d);
        #1;
        chk("int_req",       16'(int_req),       16'(m_req));
        chk("int_vector",    int_vector,         m_vec);
        chk("int_reg_write", 16'(int_reg_write), 16'(m_wr));
        chk("int_reg_i",     16'(int_reg_i),     16'(m_ri));
        chk("pending",       16'(pending),       16'(m_pending));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 4'b0000, 0, 4'b0000, 0, 0);
    endtask

    initial begin
        logic [3:0] cur_irq;
        reset = 1; irq = 0; mask_write = 0; mask_in = 0; int_ack = 0; int_done = 0;
        m_pending = 0; m_mask = '1; h1 = 0; h2 = 0; h3 = 0;
        m_phase = 0; m_winner = 0; m_req = 0; m_vec = 16'h0040; m_wr = 0; m_ri = 0;

        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        chk("rst_req", 16'(int_req), 16'h0000);
        chk("rst_vec", int_vector, 16'h0040);
        chk("rst_pending", 16'(pending), 16'h0000);

        // single IRQ2 pulse: pending at edge 3, offer at edge 4
        tick(0, 4'b0100, 0, 0, 0, 0);
        tick(0, 4'b0000, 0, 0, 0, 0);
        tick(0, 4'b0000, 0, 0, 0, 0);
        chk("edge3_pending", 16'(pending), 16'h0004);
        tick(0, 4'b0000, 0, 0, 0, 0);
        chk("edge4_req", 16'(int_req), 16'h0001);
        chk("edge4_vec", int_vector, 16'h0048);
        tick(0, 0, 0, 0, 1, 0);
        chk("ack_pulse", {14'd0, int_reg_write, int_reg_i}, 16'h0003);
        tick(0, 0, 0, 0, 0, 0);
        chk("ack_pulse_end", 16'(int_reg_write), 16'h0000);
        tick(0, 0, 0, 0, 0, 1);
        chk("done_pulse", {14'd0, int_reg_write, int_reg_i}, 16'h0002);
        idle(2);

        // IRQ1 and IRQ3 together: 1 first, then 3
        tick(0, 4'b1010, 0, 0, 0, 0);
        idle(3);
        chk("prio_vec", int_vector, 16'h0044);
        tick(0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0, 1);
        idle(1);
        chk("next_vec", int_vector, 16'h004C);
        chk("next_req", 16'(int_req), 16'h0001);

        // done while offering and ack while idle are ignored
        tick(0, 0, 0, 0, 0, 1);
        chk("done_in_req", 16'(int_req), 16'h0001);
        // rearm IRQ3 so its edge lands in the same cycle as the ack clear
        tick(0, 4'b1000, 0, 0, 0, 0);
        tick(0, 4'b0000, 0, 0, 0, 0);
        tick(0, 4'b0000, 0, 0, 1, 0);
        chk("set_wins", 16'(pending[3]), 16'h0001);
        tick(0, 0, 0, 0, 0, 1);
        idle(1);
        tick(0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1, 0);
        idle(2);

        // masked IRQ0 latches but is not offered until unmasked
        tick(0, 0, 1, 4'b1110, 0, 0);
        tick(0, 4'b0001, 0, 0, 0, 0);
        idle(4);
        chk("masked_pending", 16'(pending[0]), 16'h0001);
        chk("masked_req", 16'(int_req), 16'h0000);
        tick(0, 0, 1, 4'b1111, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        chk("unmask_req", 16'(int_req), 16'h0001);
        chk("unmask_vec", int_vector, 16'h0040);

        // reset during service aborts silently
        tick(0, 0, 0, 0, 1, 0);
        tick(1, 0, 0, 0, 0, 1);
        chk("svc_rst_wr", 16'(int_reg_write), 16'h0000);
        chk("svc_rst_vec", int_vector, 16'h0040);
        idle(2);

        cur_irq = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) cur_irq[b] = ~cur_irq[b];
            tick($urandom_range(199) == 0, cur_irq,
                 $urandom_range(19) == 0, 4'($urandom_range(15)),
                 $urandom_range(2) == 0, $urandom_range(3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
